// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct codes, ALU select encodings, control bundles
// carried into ID/EX, and the register-address width helper.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } aluSelT;

    // Control fields registered into ID/EX; an all-zero value is a bubble.
    typedef struct packed {
        logic   rfWe;
        logic   mtoRfSel;
        logic   dmWe;
        logic   aluInSel;
        logic   rfDSel;
        logic   illegal;
        aluSelT aluSel;
    } ctrlT;

    // Decode-stage view: the ID/EX controls plus flags used only for hazards and PC steering.
    typedef struct packed {
        ctrlT ctrl;
        logic isBranch;
        logic isBne;
        logic isJump;
        logic readsRt;
    } decodeT;

    function automatic int rawBits(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// NREG x DWL register file: two combinational read ports with write-through from the
// single write port, register 0 hard-wired to zero, asynchronous clear on RST_N.
module decode_regfile
    import decode_pkg::*;
#(
    parameter  int DWL  = 32,
    parameter  int NREG = 32,
    localparam int RAW  = rawBits(NREG)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [RAW-1:0] RA1,
    input  logic [RAW-1:0] RA2,
    output logic [DWL-1:0] RD1,
    output logic [DWL-1:0] RD2,
    input  logic           WE,
    input  logic [RAW-1:0] WA,
    input  logic [DWL-1:0] WD
);

    logic [DWL-1:0] regs [NREG];
    logic           wrActive;

    assign wrActive = WE && (WA != '0);

    // NOTE: the whole array is cleared on reset, so this maps to flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wrActive) begin
            regs[WA] <= WD;
        end
    end

    assign RD1 = (RA1 == '0) ? '0 : (wrActive && RA1 == WA) ? WD : regs[RA1];
    assign RD2 = (RA2 == '0) ? '0 : (wrActive && RA2 == WA) ? WD : regs[RA2];

endmodule

// File: rtl/decode_hazard_stage.sv
// Decode stage: MIPS-subset decode, branch/jump resolution with MEM forwarding, load-use and
// branch hazard stalls, and the ID/EX register. Define BNE_EN to decode op 05 as bne.
module decode_hazard_stage
    import decode_pkg::*;
#(
    parameter  int DWL       = 32,
    parameter  int NREG      = 32,
    parameter  int IMM_SHIFT = 2,
    localparam int RAW       = rawBits(NREG)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [DWL-1:0] InstrD,
    input  logic [DWL-1:0] PCp1D,
    input  logic           FlushE,
    input  logic           RFWEE,
    input  logic           MtoRFSelE,
    input  logic [RAW-1:0] WAE,
    input  logic           RFWEM,
    input  logic           MtoRFSelM,
    input  logic [RAW-1:0] WAM,
    input  logic [DWL-1:0] ALUOutM,
    input  logic           RFWEW,
    input  logic [RAW-1:0] WAW,
    input  logic [DWL-1:0] ResultW,
    output logic           StallF,
    output logic           StallD,
    output logic           PCSelD,
    output logic           JumpD,
    output logic [DWL-1:0] PCBranchD,
    output logic [DWL-1:0] PCJumpD,
    output logic           RFWEE_o,
    output logic           MtoRFSelE_o,
    output logic           DMWEE,
    output logic           ALUInSelE,
    output logic           RFDSelE,
    output logic           IllegalE,
    output logic [2:0]     ALUSelE,
    output logic [DWL-1:0] RD1E,
    output logic [DWL-1:0] RD2E,
    output logic [DWL-1:0] SImmE,
    output logic [RAW-1:0] RsE,
    output logic [RAW-1:0] RtE,
    output logic [RAW-1:0] RdE,
    output logic [4:0]     ShamtE
);

    logic [5:0]     op;
    logic [5:0]     funct;
    logic [RAW-1:0] rs;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
    logic [4:0]     shamt;
    logic [DWL-1:0] sImm;
    logic [DWL-1:0] rfRd1;
    logic [DWL-1:0] rfRd2;
    decodeT         dec;

    assign op    = InstrD[31:26];
    assign funct = InstrD[5:0];
    assign rs    = InstrD[21 +: RAW];
    assign rt    = InstrD[16 +: RAW];
    assign rd    = InstrD[11 +: RAW];
    assign shamt = InstrD[10:6];
    assign sImm  = {{(DWL-16){InstrD[15]}}, InstrD[15:0]};

    decode_regfile #(.DWL(DWL), .NREG(NREG)) uRegfile (
        .CLK   (CLK),
        .RST_N (RST_N),
        .RA1   (rs),
        .RA2   (rt),
        .RD1   (rfRd1),
        .RD2   (rfRd2),
        .WE    (RFWEW),
        .WA    (WAW),
        .WD    (ResultW)
    );

    // NOTE: dec gets a full default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        dec = '0;
        unique case (op)
            OP_RTYPE: begin
                dec.ctrl.rfWe   = 1'b1;
                dec.ctrl.rfDSel = 1'b1;
                dec.readsRt     = 1'b1;
                unique case (funct)
                    FN_ADD:  dec.ctrl.aluSel = ALU_ADD;
                    FN_SUB:  dec.ctrl.aluSel = ALU_SUB;
                    FN_AND:  dec.ctrl.aluSel = ALU_AND;
                    FN_OR:   dec.ctrl.aluSel = ALU_OR;
                    FN_SLT:  dec.ctrl.aluSel = ALU_SLT;
                    FN_SLL:  dec.ctrl.aluSel = ALU_SLL;
                    default: begin
                        dec              = '0;
                        dec.ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec.ctrl.rfWe     = 1'b1;
                dec.ctrl.mtoRfSel = 1'b1;
                dec.ctrl.aluInSel = 1'b1;
            end
            OP_SW: begin
                dec.ctrl.dmWe     = 1'b1;
                dec.ctrl.aluInSel = 1'b1;
                dec.readsRt       = 1'b1;
            end
            OP_ADDI: begin
                dec.ctrl.rfWe     = 1'b1;
                dec.ctrl.aluInSel = 1'b1;
            end
            OP_BEQ: begin
                dec.ctrl.aluSel = ALU_SUB;
                dec.isBranch    = 1'b1;
                dec.readsRt     = 1'b1;
            end
`ifdef BNE_EN
            OP_BNE: begin
                dec.ctrl.aluSel = ALU_SUB;
                dec.isBranch    = 1'b1;
                dec.isBne       = 1'b1;
                dec.readsRt     = 1'b1;
            end
`endif
            OP_J:    dec.isJump = 1'b1;
            default: dec.ctrl.illegal = 1'b1;
        endcase
    end

    // Branch comparison forwards a MEM-stage ALU result; anything younger forces a stall instead.
    logic [DWL-1:0] brA;
    logic [DWL-1:0] brB;
    logic           lwStall;
    logic           brStall;
    logic           stall;
    logic           taken;

    assign brA = (RFWEM && WAM != '0 && WAM == rs) ? ALUOutM : rfRd1;
    assign brB = (RFWEM && WAM != '0 && WAM == rt) ? ALUOutM : rfRd2;

    assign lwStall = RFWEE && MtoRFSelE && (WAE != '0) &&
                     ((WAE == rs) || ((WAE == rt) && dec.readsRt));
    assign brStall = dec.isBranch &&
                     ((RFWEE && (WAE != '0) && ((WAE == rs) || (WAE == rt))) ||
                      (MtoRFSelM && (WAM != '0) && ((WAM == rs) || (WAM == rt))));
    assign stall   = lwStall || brStall;
    assign taken   = dec.isBranch && (dec.isBne ? (brA != brB) : (brA == brB));

    assign StallF    = stall;
    assign StallD    = stall;
    assign PCSelD    = !stall && taken;
    assign JumpD     = !stall && dec.isJump;
    assign PCBranchD = PCp1D + (sImm << IMM_SHIFT);
    assign PCJumpD   = {PCp1D[DWL-1:26], InstrD[25:0]};

    ctrlT ctrlE;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrlE  <= '0;
            RD1E   <= '0;
            RD2E   <= '0;
            SImmE  <= '0;
            RsE    <= '0;
            RtE    <= '0;
            RdE    <= '0;
            ShamtE <= '0;
        end else if (FlushE || stall) begin
            ctrlE  <= '0;
            RD1E   <= '0;
            RD2E   <= '0;
            SImmE  <= '0;
            RsE    <= '0;
            RtE    <= '0;
            RdE    <= '0;
            ShamtE <= '0;
        end else begin
            ctrlE  <= dec.ctrl;
            RD1E   <= rfRd1;
            RD2E   <= rfRd2;
            SImmE  <= sImm;
            RsE    <= rs;
            RtE    <= rt;
            RdE    <= rd;
            ShamtE <= shamt;
        end
    end

    assign RFWEE_o     = ctrlE.rfWe;
    assign MtoRFSelE_o = ctrlE.mtoRfSel;
    assign DMWEE       = ctrlE.dmWe;
    assign ALUInSelE   = ctrlE.aluInSel;
    assign RFDSelE     = ctrlE.rfDSel;
    assign IllegalE    = ctrlE.illegal;
    assign ALUSelE     = ctrlE.aluSel;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Scoreboard bench for decode_hazard_stage: directed vectors push expected responses, a
// negedge monitor compares combinational outputs that cycle and ID/EX outputs one edge later.
module tb_decode_hazard_stage;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] InstrD = '0;
    logic [31:0] PCp1D = 32'h100;
    logic        FlushE = 1'b0;
    logic        RFWEE = 1'b0, MtoRFSelE = 1'b0;
    logic [4:0]  WAE = '0;
    logic        RFWEM = 1'b0, MtoRFSelM = 1'b0;
    logic [4:0]  WAM = '0;
    logic [31:0] ALUOutM = '0;
    logic        RFWEW = 1'b0;
    logic [4:0]  WAW = '0;
    logic [31:0] ResultW = '0;
    logic        StallF, StallD, PCSelD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        RFWEE_o, MtoRFSelE_o, DMWEE, ALUInSelE, RFDSelE, IllegalE;
    logic [2:0]  ALUSelE;
    logic [31:0] RD1E, RD2E, SImmE;
    logic [4:0]  RsE, RtE, RdE, ShamtE;

    decode_hazard_stage dut (
        .CLK(CLK), .RST_N(RST_N), .InstrD(InstrD), .PCp1D(PCp1D), .FlushE(FlushE),
        .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE), .WAE(WAE),
        .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .WAM(WAM), .ALUOutM(ALUOutM),
        .RFWEW(RFWEW), .WAW(WAW), .ResultW(ResultW),
        .StallF(StallF), .StallD(StallD), .PCSelD(PCSelD), .JumpD(JumpD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .RFWEE_o(RFWEE_o), .MtoRFSelE_o(MtoRFSelE_o), .DMWEE(DMWEE), .ALUInSelE(ALUInSelE),
        .RFDSelE(RFDSelE), .IllegalE(IllegalE), .ALUSelE(ALUSelE),
        .RD1E(RD1E), .RD2E(RD2E), .SImmE(SImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE), .ShamtE(ShamtE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic stall; logic pcSel; logic jump; } combT;
    typedef struct packed {
        logic rfWe; logic mtoRf; logic dmWe; logic aluIn; logic rfDSel; logic illegal;
        logic [2:0] aluSel; logic [31:0] rd1; logic [31:0] rd2; logic [31:0] simm;
        logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic [4:0] shamt;
    } eT;
    typedef struct {
        string name; combT c; logic chkTgt; logic [31:0] pcBranch; logic [31:0] pcJump; eT e;
    } expT;

    localparam eT BUBBLE = '0;

    expT q[$];
    int  checks = 0;
    int  errors = 0;
    bit  havePend = 0;
    eT   gotE;
    combT gotC;

    assign gotE = {RFWEE_o, MtoRFSelE_o, DMWEE, ALUInSelE, RFDSelE, IllegalE, ALUSelE,
                   RD1E, RD2E, SImmE, RsE, RtE, RdE, ShamtE};
    assign gotC = {StallD, PCSelD, JumpD};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic eT mkE(input logic rfWe, mtoRf, dmWe, aluIn, rfDSel, illegal,
                              input logic [2:0] aluSel, input logic [31:0] rd1, rd2, simm,
                              input logic [4:0] rs, rt, rd, shamt);
        return {rfWe, mtoRf, dmWe, aluIn, rfDSel, illegal, aluSel, rd1, rd2, simm, rs, rt, rd, shamt};
    endfunction

    task automatic push(input string name, input combT c, input logic chkTgt,
                        input logic [31:0] pb, input logic [31:0] pj, input eT e);
        expT x;
        x.name = name; x.c = c; x.chkTgt = chkTgt; x.pcBranch = pb; x.pcJump = pj; x.e = e;
        q.push_back(x);
    endtask

    // Monitor: comb outputs belong to the current cycle, E outputs to the previous one.
    initial begin
        expT cur, pend;
        forever begin
            @(negedge CLK);
            if (havePend) check({pend.name, "_E"}, gotE, pend.e);
            havePend = 0;
            if (q.size() > 0) begin
                cur = q.pop_front();
                check({cur.name, "_ctl"}, gotC, cur.c);
                check({cur.name, "_stallF"}, StallF, cur.c.stall);
                if (cur.chkTgt) begin
                    check({cur.name, "_pcBranch"}, PCBranchD, cur.pcBranch);
                    check({cur.name, "_pcJump"}, PCJumpD, cur.pcJump);
                end
                pend = cur;
                havePend = 1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        FlushE = 0; RFWEE = 0; MtoRFSelE = 0; WAE = 0;
        RFWEM = 0; MtoRFSelM = 0; WAM = 0; ALUOutM = 0;
        RFWEW = 0; WAW = 0; ResultW = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q.size() > 0 || havePend); i++) @(negedge CLK);
        #1;
        check("drain_pending", (q.size() != 0) || havePend, 1'b0);
    endtask

    initial begin
        #2 RST_N = 0;
        #1 check("reset_initial", gotE, BUBBLE);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1;

        step(); InstrD = 32'h0; RFWEW = 1; WAW = 1; ResultW = 32'h11;
        push("wr1", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,5, 0,0,0, 0,0,0,0));
        step(); InstrD = 32'h0; RFWEW = 1; WAW = 2; ResultW = 32'h22;
        push("wr2", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,5, 0,0,0, 0,0,0,0));
        step(); InstrD = 32'h00A01820; RFWEW = 1; WAW = 5; ResultW = 32'h1234;
        push("wthru", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 32'h1234,0,32'h1820, 5,0,3,0));
        step(); InstrD = 32'h00051820; RFWEW = 1; WAW = 0; ResultW = 32'hDEAD;
        push("r0wr", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 0,32'h1234,32'h1820, 0,5,3,0));
        step(); InstrD = 32'h00412020; RFWEE = 1; MtoRFSelE = 1; WAE = 2;
        push("lwuse", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h00412020;
        push("lwuse_go", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 32'h22,32'h11,32'h2020, 2,1,4,0));
        step(); InstrD = 32'h20220005; RFWEE = 1; MtoRFSelE = 1; WAE = 2;
        push("addi_rt", 3'b000, 0, 0, 0, mkE(1,0,0,1,0,0,0, 32'h11,32'h22,5, 1,2,0,0));
        step(); InstrD = 32'hAC22FFFC; RFWEE = 1; MtoRFSelE = 1; WAE = 2;
        push("sw_stall", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'hAC22FFFC;
        push("sw_go", 3'b000, 0, 0, 0, mkE(0,0,1,1,0,0,0, 32'h11,32'h22,32'hFFFFFFFC, 1,2,31,31));
        step(); InstrD = 32'h10220003; RFWEE = 1; WAE = 1;
        push("beq_exstall", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h10220003; RFWEM = 1; WAM = 1; ALUOutM = 32'h22;
        push("beq_fwd", 3'b010, 1, 32'h10C, 32'h00220003, mkE(0,0,0,0,0,0,1, 32'h11,32'h22,3, 1,2,0,0));
        step(); InstrD = 32'h10220003; RFWEM = 1; MtoRFSelM = 1; WAM = 2; ALUOutM = 32'h11;
        push("beq_memld", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h1022FFFE;
        push("beq_nt", 3'b000, 1, 32'hF8, 32'h0022FFFE,
             mkE(0,0,0,0,0,0,1, 32'h11,32'h22,32'hFFFFFFFE, 1,2,31,31));
`ifdef BNE_EN
        step(); InstrD = 32'h14220004;
        push("bne", 3'b010, 1, 32'h110, 32'h00220004, mkE(0,0,0,0,0,0,1, 32'h11,32'h22,4, 1,2,0,0));
        step(); InstrD = 32'h14220004; RFWEE = 1; WAE = 2;
        push("bne_stall", 3'b100, 0, 0, 0, BUBBLE);
`else
        step(); InstrD = 32'h14220004;
        push("bne", 3'b000, 1, 32'h110, 32'h00220004, mkE(0,0,0,0,0,1,0, 32'h11,32'h22,4, 1,2,0,0));
        step(); InstrD = 32'h14220004; RFWEE = 1; WAE = 2;
        push("bne_stall", 3'b000, 0, 0, 0, mkE(0,0,0,0,0,1,0, 32'h11,32'h22,4, 1,2,0,0));
`endif
        step(); InstrD = 32'h8C260008; FlushE = 1;
        push("flush_lw", 3'b000, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h0BFFFFFF; PCp1D = 32'hF0000004;
        push("jump", 3'b001, 1, 32'hF0000000, 32'hF3FFFFFF,
             mkE(0,0,0,0,0,0,0, 0,0,32'hFFFFFFFF, 31,31,31,31));
        step(); InstrD = 32'h0BFFFFFF; RFWEE = 1; MtoRFSelE = 1; WAE = 31;
        push("jump_stall", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h00000021; PCp1D = 32'h100;
        push("bad_funct", 3'b000, 0, 0, 0, mkE(0,0,0,0,0,1,0, 0,0,32'h21, 0,0,0,0));
        step(); InstrD = 32'h00002020; RFWEE = 1; MtoRFSelE = 1; WAE = 0;
        push("wae_zero", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 0,0,32'h2020, 0,0,4,0));
        step(); InstrD = 32'h00412020; FlushE = 1; RFWEE = 1; MtoRFSelE = 1; WAE = 2;
        push("flush_stall", 3'b100, 0, 0, 0, BUBBLE);
        step(); InstrD = 32'h00412020;
        push("after_fs", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 32'h22,32'h11,32'h2020, 2,1,4,0));
        step(); InstrD = 32'h00223822;
        push("sub", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,1, 32'h11,32'h22,32'h3822, 1,2,7,0));
        step(); InstrD = 32'h0041382A;
        push("slt", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,4, 32'h22,32'h11,32'h382A, 2,1,7,0));
        step(); InstrD = 32'h00221824;
        push("and", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,2, 32'h11,32'h22,32'h1824, 1,2,3,0));
        step(); InstrD = 32'h00011080;
        push("sll", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,5, 0,32'h11,32'h1080, 0,1,2,2));
        drain();

        // Mid-run asynchronous reset: E outputs clear without waiting for an edge.
        @(posedge CLK);
        #1 RST_N = 0;
        #1 check("reset_async", gotE, BUBBLE);
        @(posedge CLK);
        #1 RST_N = 1;
        step(); InstrD = 32'h00221820;
        push("rf_cleared", 3'b000, 0, 0, 0, mkE(1,0,0,0,1,0,0, 0,0,32'h1820, 1,2,3,0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
